// File: rtl/fifo_pkg.sv
// Shared constants and types for the fifo_final single-clock FIFO.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;
  localparam int ADDR_WIDTH_DEF = $clog2(DEPTH_DEF);

  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Storage array for fifo_final: one write port and one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto plain RAM; stale words are
  // never visible because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data holds its last value whenever no read is accepted.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : fifo_mem

// File: rtl/fifo_final.sv
// Single-clock FIFO: wrap-bit pointers, occupancy counter, registered
// overflow/underflow pulses around a fifo_mem storage array.
module fifo_final
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wptr_d, wptr_q;
  logic [ADDR_WIDTH:0] rptr_d, rptr_q;
  logic [ADDR_WIDTH:0] usedw_d, usedw_q;
  logic                overflow_d, overflow_q;
  logic                underflow_d, underflow_q;
  logic                wr_acc, rd_acc;

  // Flags come only from registered pointers; the MSB is the wrap bit.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                 (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    wr_acc      = wrreq & ~full;
    rd_acc      = rdreq & ~empty;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    usedw_d     = usedw_q;
    overflow_d  = wrreq & full;
    underflow_d = rdreq & empty;

    if (wr_acc) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + PTR_ONE;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   usedw_d = usedw_q + PTR_ONE;
      2'b01:   usedw_d = usedw_q - PTR_ONE;
      default: usedw_d = usedw_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      usedw_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      usedw_q     <= usedw_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wptr_q[ADDR_WIDTH-1:0]),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rptr_q[ADDR_WIDTH-1:0]),
    .rdata (data_out)
  );

  assign usedw     = usedw_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule : fifo_final

// File: tb/tb_fifo_final.sv
// Scoreboard bench for fifo_final: driver models the FIFO and queues expected
// read data; a monitor compares data_out the cycle after each accepted read.
module tb_fifo_final;
  import fifo_pkg::*;

  localparam int DEPTH = DEPTH_DEF;
  localparam int AW    = ADDR_WIDTH_DEF;

  logic          clk = 1'b0;
  logic          rst_n;
  data_t         data_in;
  logic          wrreq;
  logic          rdreq;
  data_t         data_out;
  logic          full;
  logic          empty;
  logic [AW:0]   usedw;
  logic          overflow;
  logic          underflow;

  int n_cmp = 0;
  int n_err = 0;

  data_t model_q[$];
  data_t exp_q[$];
  data_t last_out;

  always #5 clk = ~clk;

  fifo_final dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .wrreq     (wrreq),
    .rdreq     (rdreq),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .usedw     (usedw),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag, input logic exp_ovf, input logic exp_unf);
    check({tag, " usedw"}, 32'(usedw), 32'(model_q.size()));
    check({tag, " empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, " full"}, 32'(full), 32'(model_q.size() == DEPTH));
    check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, " underflow"}, 32'(underflow), 32'(exp_unf));
  endtask

  // One clock of stimulus, driven from the falling edge; flags checked at the
  // next falling edge against the model.
  task automatic cycle(input string tag, input logic wr, input logic rd, input data_t din);
    logic w_ok, r_ok;
    wrreq   = wr;
    rdreq   = rd;
    data_in = din;
    w_ok = wr && (model_q.size() < DEPTH);
    r_ok = rd && (model_q.size() > 0);
    @(posedge clk);
    if (r_ok) begin
      last_out = model_q.pop_front();
      exp_q.push_back(last_out);
    end
    if (w_ok) model_q.push_back(din);
    @(negedge clk);
    wrreq = 1'b0;
    rdreq = 1'b0;
    check_flags(tag, wr && !w_ok, rd && !r_ok);
  endtask

  // Monitor: a read accepted at this edge must show its word on data_out by
  // the following falling edge.
  initial begin
    logic rd_seen;
    forever begin
      @(posedge clk);
      rd_seen = rst_n && rdreq && !empty;
      @(negedge clk);
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected_read: got %0d expected no read (t=%0t)", data_out, $time);
        end else begin
          check("sb data_out", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    wrreq    = 1'b1;
    rdreq    = 1'b1;
    data_in  = 8'hAA;
    last_out = '0;

    // Reset held with both requests active: nothing may move.
    repeat (3) @(negedge clk);
    check("rst data_out", 32'(data_out), 32'd0);
    check_flags("rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    @(negedge clk);
    check_flags("post_rst", 1'b0, 1'b0);

    // Basic ordering.
    for (int i = 1; i <= 3; i++) cycle("basic_wr", 1'b1, 1'b0, data_t'(i));
    for (int i = 1; i <= 3; i++) cycle("basic_rd", 1'b0, 1'b1, '0);
    cycle("basic_idle", 1'b0, 1'b0, '0);

    // Fill, overflow on the 17th write, drain.
    for (int i = 1; i <= DEPTH; i++) cycle("fill_wr", 1'b1, 1'b0, data_t'(i));
    check("fill full", 32'(full), 32'd1);
    cycle("ovf_wr", 1'b1, 1'b0, 8'd99);
    cycle("ovf_idle", 1'b0, 1'b0, '0);
    for (int i = 1; i <= DEPTH; i++) cycle("drain_rd", 1'b0, 1'b1, '0);
    check("drain empty", 32'(empty), 32'd1);

    // Underflow: data_out must hold the last word read.
    cycle("unf_rd", 1'b0, 1'b1, '0);
    check("unf hold data_out", 32'(data_out), 32'd16);
    cycle("unf_idle", 1'b0, 1'b0, '0);

    // Streaming through the pointer wrap; first cycle underflows on empty.
    for (int i = 0; i < 40; i++) begin
      cycle("stream", 1'b1, 1'b1, data_t'((i % 11) + 1));
      if (usedw > 1) check("stream usedw bound", 32'(usedw), 32'd1);
    end
    cycle("stream_tail", 1'b0, 1'b1, '0);
    cycle("stream_idle", 1'b0, 1'b0, '0);

    // Mid-operation reset.
    for (int i = 0; i < 5; i++) cycle("mid_wr", 1'b1, 1'b0, data_t'(8'h40 + i));
    rst_n = 1'b0;
    #1;
    model_q.delete();
    last_out = '0;
    check("mid_rst data_out", 32'(data_out), 32'd0);
    check("mid_rst empty", 32'(empty), 32'd1);
    check("mid_rst usedw", 32'(usedw), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cycle("post_mid_wr", 1'b1, 1'b0, 8'd7);
    cycle("post_mid_rd", 1'b0, 1'b1, '0);
    check("post_mid data_out", 32'(data_out), 32'd7);
    cycle("final_idle", 1'b0, 1'b0, '0);

    check("sb leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fifo_final

// File: doc/fifo_final.md
Name: fifo_final

Overview:
- Single-clock, synchronous first-in-first-out buffer for 8-bit data words.
- Decouples a producer and consumer that run on the same clock but issue requests independently.
- Provides full/empty/occupancy status and one-cycle overflow/underflow error pulses.
- Used as a generic rate-smoothing buffer between datapath stages.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out in bits.
- DEPTH, 16, number of storage entries; must be a power of two, at least 2.
- ADDR_WIDTH, 4, log2(DEPTH); storage index width.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous reset, active-low; release is synchronous to clk by the system.
- data_in  input  DATA_WIDTH  write data, sampled when a write is accepted.
- wrreq  input  1  write request.
- rdreq  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when DEPTH entries are stored.
- empty  output  1  high when 0 entries are stored.
- usedw  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: wrreq while full, write dropped.
- underflow  output  1  one-cycle pulse: rdreq while empty, read ignored.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and usedw clear to 0; empty=1, full=0.
  - data_out=0; overflow=0; underflow=0.
  - Storage contents are not cleared.
- Pointers: write and read pointers are ADDR_WIDTH+1 bits; the extra MSB is a wrap bit.
  - empty when pointers are equal; full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Write accepted = wrreq & ~full (full sampled before the edge).
  - On accept: mem[wptr low bits] <= data_in; wptr increments.
- Read accepted = rdreq & ~empty (empty sampled before the edge).
  - On accept: data_out <= mem[rptr low bits]; rptr increments.
  - Latency: data appears on data_out the cycle after the accepting edge.
  - No fall-through: a word written in cycle N is readable at the earliest at edge N+1.
- data_out holds its last value when no read is accepted, including after the FIFO drains.
- Simultaneous wrreq and rdreq:
  - Not full and not empty: both accepted; usedw unchanged.
  - When empty: only the write is accepted; underflow pulses.
  - When full: only the read is accepted; overflow pulses; the write data is lost.
- usedw: +1 on write-only, -1 on read-only, unchanged otherwise. full, empty and usedw are registered or derived from registered pointers only, never from the inputs.
- overflow/underflow are registered and high for exactly the cycle following the offending edge.
- Reset asserted mid-operation immediately empties the FIFO; data in flight is discarded.
- X on wrreq/rdreq is not supported; the inputs must be valid every cycle outside reset.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_WIDTH and DEPTH defaults.
  - A derived ADDR_WIDTH constant.
  - A data_t typedef of DATA_WIDTH bits.
- One natural sub-module, fifo_mem: the storage array.
  - One write port: clk, we, waddr, wdata.
  - One read port: registered output rdata on re.
- Pointer and flag logic stays in fifo_final.

Test Plan:
- Reset: hold rst_n=0 with wrreq=rdreq=1 -> data_out=0, empty=1, full=0, usedw=0; no pointer movement.
- Basic order: write 1,2,3 on consecutive cycles, then read 3 cycles -> data_out=1,2,3, each one cycle after its read edge; empty=1 afterwards.
- Fill and overflow:
  - Write 1..16 -> full=1, usedw=16.
  - A 17th write of 99 -> overflow pulses once; 99 is dropped.
  - 16 reads -> 1..16.
- Underflow: rdreq on an empty FIFO -> underflow pulses, data_out holds its previous value, usedw stays 0.
- Streaming with wrap: wrreq=rdreq=1 for 40 cycles with data 1..11 repeating -> output is the same sequence delayed, with no loss; pointers wrap twice; usedw stays bounded at 1 or below.
- Mid-operation reset: write 5 words, pulse rst_n low -> empty=1, usedw=0, data_out=0; a following write of 7 then read -> data_out=7.
